// File: rtl/rs_issue_scheduler.sv
// Wakeup/select scheduler for a 16-entry reservation station: tracks source
// readiness, snoops completion tags, and offers one ready index per FU per cycle.
module rs_issue_scheduler #(
  parameter int NUM_RS = 16,
  parameter int TAG_W  = 6,
  parameter int NUM_FU = 3,
  localparam int IDX_W = $clog2(NUM_RS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_valid_a,
  input  logic              alloc_valid_b,
  input  logic [IDX_W-1:0]  alloc_idx_a,
  input  logic [IDX_W-1:0]  alloc_idx_b,
  input  logic [1:0]        alloc_fu_a,
  input  logic [1:0]        alloc_fu_b,
  input  logic [TAG_W-1:0]  alloc_ps1_a,
  input  logic [TAG_W-1:0]  alloc_ps2_a,
  input  logic [TAG_W-1:0]  alloc_ps1_b,
  input  logic [TAG_W-1:0]  alloc_ps2_b,
  input  logic              alloc_rdy1_a,
  input  logic              alloc_rdy2_a,
  input  logic              alloc_rdy1_b,
  input  logic              alloc_rdy2_b,
  input  logic [NUM_FU-1:0] wake_valid,
  input  logic [TAG_W-1:0]  wake_tag_0,
  input  logic [TAG_W-1:0]  wake_tag_1,
  input  logic [TAG_W-1:0]  wake_tag_2,
  input  logic              flush,
  output logic [NUM_FU-1:0] issue_valid,
  output logic [IDX_W-1:0]  issue_idx_0,
  output logic [IDX_W-1:0]  issue_idx_1,
  output logic [IDX_W-1:0]  issue_idx_2,
  input  logic [NUM_FU-1:0] issue_ready,
  output logic [4:0]        free_count,
  output logic              dispatch_stall,
  output logic              alloc_err
);

  logic [NUM_RS-1:0] ent_valid, ent_picked, ent_rdy1, ent_rdy2;
  logic [1:0]        ent_fu   [NUM_RS];
  logic [TAG_W-1:0]  ent_tag1 [NUM_RS];
  logic [TAG_W-1:0]  ent_tag2 [NUM_RS];

  logic [IDX_W-1:0]  idx_q    [NUM_FU];
  logic [IDX_W-1:0]  rr_ptr   [NUM_FU];
  logic [IDX_W-1:0]  next_ptr [NUM_FU];
  logic [IDX_W-1:0]  sel_idx  [NUM_FU];
  logic [TAG_W-1:0]  wtag     [NUM_FU];

  logic [NUM_FU-1:0] hs, load, sel_found;
  logic [NUM_RS-1:0] eligible, hit1, hit2;
  logic              hit_a1, hit_a2, hit_b1, hit_b2;
  logic              accept_a, accept_b, err_now;
  logic [1:0]        n_hs, n_acc;

  assign wtag[0]     = wake_tag_0;
  assign wtag[1]     = wake_tag_1;
  assign wtag[2]     = wake_tag_2;
  assign issue_idx_0 = idx_q[0];
  assign issue_idx_1 = idx_q[1];
  assign issue_idx_2 = idx_q[2];

  assign hs             = issue_valid & issue_ready;
  assign load           = ~issue_valid | hs;
  assign eligible       = ent_valid & ~ent_picked & ent_rdy1 & ent_rdy2;
  assign dispatch_stall = free_count < 5'd2;

  always_comb begin
    hit1   = '0;
    hit2   = '0;
    hit_a1 = 1'b0;
    hit_a2 = 1'b0;
    hit_b1 = 1'b0;
    hit_b2 = 1'b0;
    for (int unsigned f = 0; f < NUM_FU; f++) begin
      if (wake_valid[f]) begin
        for (int unsigned e = 0; e < NUM_RS; e++) begin
          if (ent_tag1[e] == wtag[f]) hit1[e] = 1'b1;
          if (ent_tag2[e] == wtag[f]) hit2[e] = 1'b1;
        end
        if (alloc_ps1_a == wtag[f]) hit_a1 = 1'b1;
        if (alloc_ps2_a == wtag[f]) hit_a2 = 1'b1;
        if (alloc_ps1_b == wtag[f]) hit_b1 = 1'b1;
        if (alloc_ps2_b == wtag[f]) hit_b2 = 1'b1;
      end
    end
  end

  always_comb begin
    accept_a = alloc_valid_a && !ent_valid[alloc_idx_a] && (alloc_fu_a != 2'd3);
    accept_b = alloc_valid_b && !ent_valid[alloc_idx_b] && (alloc_fu_b != 2'd3)
               && !(alloc_valid_a && (alloc_idx_a == alloc_idx_b));
    err_now  = (alloc_valid_a && !accept_a) || (alloc_valid_b && !accept_b);
    n_acc    = {1'b0, accept_a} + {1'b0, accept_b};
    n_hs     = {1'b0, hs[0]} + {1'b0, hs[1]} + {1'b0, hs[2]};
  end

  // A port that handshakes this cycle scans from just past the index it is
  // retiring, so back-to-back picks already honour the updated pointer.
  always_comb begin
    logic [IDX_W-1:0] start;
    int unsigned      e;
    start     = '0;
    e         = 0;
    sel_found = '0;
    for (int unsigned f = 0; f < NUM_FU; f++) begin
      sel_idx[f]  = '0;
      next_ptr[f] = (32'(idx_q[f]) == NUM_RS - 1) ? '0 : idx_q[f] + IDX_W'(1);
    end
    for (int unsigned f = 0; f < NUM_FU; f++) begin
      start = hs[f] ? next_ptr[f] : rr_ptr[f];
      for (int unsigned k = 0; k < NUM_RS; k++) begin
        e = (32'(start) + k) % NUM_RS;
        if (!sel_found[f] && eligible[e] && (ent_fu[e] == 2'(f))) begin
          sel_found[f] = 1'b1;
          sel_idx[f]   = IDX_W'(e);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_valid  <= '0;
      ent_picked <= '0;
      ent_rdy1   <= '0;
      ent_rdy2   <= '0;
      for (int unsigned e = 0; e < NUM_RS; e++) begin
        ent_fu[e]   <= '0;
        ent_tag1[e] <= '0;
        ent_tag2[e] <= '0;
      end
    end else if (flush) begin
      ent_valid  <= '0;
      ent_picked <= '0;
    end else begin
      ent_rdy1 <= ent_rdy1 | (ent_valid & hit1);
      ent_rdy2 <= ent_rdy2 | (ent_valid & hit2);
      for (int unsigned f = 0; f < NUM_FU; f++) begin
        if (hs[f]) begin
          ent_valid[idx_q[f]]  <= 1'b0;
          ent_picked[idx_q[f]] <= 1'b0;
        end
        if (load[f] && sel_found[f]) ent_picked[sel_idx[f]] <= 1'b1;
      end
      if (accept_a) begin
        ent_valid[alloc_idx_a]  <= 1'b1;
        ent_picked[alloc_idx_a] <= 1'b0;
        ent_fu[alloc_idx_a]     <= alloc_fu_a;
        ent_tag1[alloc_idx_a]   <= alloc_ps1_a;
        ent_tag2[alloc_idx_a]   <= alloc_ps2_a;
        ent_rdy1[alloc_idx_a]   <= alloc_rdy1_a | hit_a1;
        ent_rdy2[alloc_idx_a]   <= alloc_rdy2_a | hit_a2;
      end
      if (accept_b) begin
        ent_valid[alloc_idx_b]  <= 1'b1;
        ent_picked[alloc_idx_b] <= 1'b0;
        ent_fu[alloc_idx_b]     <= alloc_fu_b;
        ent_tag1[alloc_idx_b]   <= alloc_ps1_b;
        ent_tag2[alloc_idx_b]   <= alloc_ps2_b;
        ent_rdy1[alloc_idx_b]   <= alloc_rdy1_b | hit_b1;
        ent_rdy2[alloc_idx_b]   <= alloc_rdy2_b | hit_b2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid <= '0;
      free_count  <= 5'(NUM_RS);
      alloc_err   <= 1'b0;
      for (int unsigned f = 0; f < NUM_FU; f++) begin
        idx_q[f]  <= '0;
        rr_ptr[f] <= '0;
      end
    end else if (flush) begin
      issue_valid <= '0;
      free_count  <= 5'(NUM_RS);
    end else begin
      for (int unsigned f = 0; f < NUM_FU; f++) begin
        if (hs[f]) rr_ptr[f] <= next_ptr[f];
        if (load[f]) begin
          issue_valid[f] <= sel_found[f];
          if (sel_found[f]) idx_q[f] <= sel_idx[f];
        end
      end
      free_count <= free_count + {3'b0, n_hs} - {3'b0, n_acc};
      if (err_now) alloc_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed bench for rs_issue_scheduler: a per-entry behavioural model is
// compared against the DUT every cycle, plus hand-computed spot checks.
module tb_rs_issue_scheduler;
  localparam int NRS = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       alloc_valid_a, alloc_valid_b;
  logic [3:0] alloc_idx_a, alloc_idx_b;
  logic [1:0] alloc_fu_a, alloc_fu_b;
  logic [5:0] alloc_ps1_a, alloc_ps2_a, alloc_ps1_b, alloc_ps2_b;
  logic       alloc_rdy1_a, alloc_rdy2_a, alloc_rdy1_b, alloc_rdy2_b;
  logic [2:0] wake_valid;
  logic [5:0] wake_tag_0, wake_tag_1, wake_tag_2;
  logic       flush;
  logic [2:0] issue_valid;
  logic [3:0] issue_idx_0, issue_idx_1, issue_idx_2;
  logic [2:0] issue_ready;
  logic [4:0] free_count;
  logic       dispatch_stall, alloc_err;

  rs_issue_scheduler #(.NUM_RS(16), .TAG_W(6), .NUM_FU(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid_a(alloc_valid_a), .alloc_valid_b(alloc_valid_b),
    .alloc_idx_a(alloc_idx_a), .alloc_idx_b(alloc_idx_b),
    .alloc_fu_a(alloc_fu_a), .alloc_fu_b(alloc_fu_b),
    .alloc_ps1_a(alloc_ps1_a), .alloc_ps2_a(alloc_ps2_a),
    .alloc_ps1_b(alloc_ps1_b), .alloc_ps2_b(alloc_ps2_b),
    .alloc_rdy1_a(alloc_rdy1_a), .alloc_rdy2_a(alloc_rdy2_a),
    .alloc_rdy1_b(alloc_rdy1_b), .alloc_rdy2_b(alloc_rdy2_b),
    .wake_valid(wake_valid), .wake_tag_0(wake_tag_0), .wake_tag_1(wake_tag_1),
    .wake_tag_2(wake_tag_2), .flush(flush), .issue_valid(issue_valid),
    .issue_idx_0(issue_idx_0), .issue_idx_1(issue_idx_1), .issue_idx_2(issue_idx_2),
    .issue_ready(issue_ready), .free_count(free_count),
    .dispatch_stall(dispatch_stall), .alloc_err(alloc_err)
  );

  always #5 clk = ~clk;

  // Model state: what each RS slot holds and what each port is offering.
  bit m_valid[NRS], m_picked[NRS], m_r1[NRS], m_r2[NRS];
  int m_fu[NRS], m_t1[NRS], m_t2[NRS];
  bit m_iv[3];
  int m_idx[3], m_ptr[3];
  bit m_err;

  int n_run = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int dut_idx(input int f);
    case (f)
      0:       return int'(issue_idx_0);
      1:       return int'(issue_idx_1);
      default: return int'(issue_idx_2);
    endcase
  endfunction

  function automatic bit woken(input int tag);
    if (wake_valid[0] && int'(wake_tag_0) == tag) return 1'b1;
    if (wake_valid[1] && int'(wake_tag_1) == tag) return 1'b1;
    if (wake_valid[2] && int'(wake_tag_2) == tag) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_free();
    int c = NRS;
    for (int e = 0; e < NRS; e++) if (m_valid[e]) c--;
    return c;
  endfunction

  task automatic model_reset();
    for (int e = 0; e < NRS; e++) begin
      m_valid[e] = 0; m_picked[e] = 0; m_r1[e] = 0; m_r2[e] = 0;
      m_fu[e] = 0; m_t1[e] = 0; m_t2[e] = 0;
    end
    for (int f = 0; f < 3; f++) begin
      m_iv[f] = 0; m_idx[f] = 0; m_ptr[f] = 0;
    end
    m_err = 0;
  endtask

  // Advance the model by one clock edge using the inputs held before the edge.
  task automatic model_step();
    bit hs[3];
    bit elig[NRS];
    bit was_valid[NRS];
    bit ok_a, ok_b;
    int ia, ib, start, best, bestd, d;
    for (int f = 0; f < 3; f++) hs[f] = m_iv[f] && issue_ready[f];
    if (flush) begin
      for (int e = 0; e < NRS; e++) begin m_valid[e] = 0; m_picked[e] = 0; end
      for (int f = 0; f < 3; f++) m_iv[f] = 0;
    end else begin
      for (int e = 0; e < NRS; e++) begin
        was_valid[e] = m_valid[e];
        elig[e] = m_valid[e] && !m_picked[e] && m_r1[e] && m_r2[e];
      end
      ia = int'(alloc_idx_a);
      ib = int'(alloc_idx_b);
      ok_a = alloc_valid_a && !was_valid[ia] && alloc_fu_a != 2'd3;
      ok_b = alloc_valid_b && !was_valid[ib] && alloc_fu_b != 2'd3 && !(alloc_valid_a && ia == ib);
      if ((alloc_valid_a && !ok_a) || (alloc_valid_b && !ok_b)) m_err = 1;
      for (int e = 0; e < NRS; e++)
        if (was_valid[e]) begin
          if (woken(m_t1[e])) m_r1[e] = 1;
          if (woken(m_t2[e])) m_r2[e] = 1;
        end
      for (int f = 0; f < 3; f++)
        if (hs[f]) begin m_valid[m_idx[f]] = 0; m_picked[m_idx[f]] = 0; end
      for (int f = 0; f < 3; f++)
        if (!m_iv[f] || hs[f]) begin
          start = hs[f] ? (m_idx[f] + 1) % NRS : m_ptr[f];
          if (hs[f]) m_ptr[f] = start;
          best = -1; bestd = NRS;
          for (int e = 0; e < NRS; e++)
            if (elig[e] && m_fu[e] == f) begin
              d = (e - start + NRS) % NRS;
              if (d < bestd) begin bestd = d; best = e; end
            end
          m_iv[f] = (best >= 0);
          if (best >= 0) begin m_idx[f] = best; m_picked[best] = 1; end
        end
      if (ok_a) begin
        m_valid[ia] = 1; m_picked[ia] = 0; m_fu[ia] = int'(alloc_fu_a);
        m_t1[ia] = int'(alloc_ps1_a); m_t2[ia] = int'(alloc_ps2_a);
        m_r1[ia] = alloc_rdy1_a || woken(int'(alloc_ps1_a));
        m_r2[ia] = alloc_rdy2_a || woken(int'(alloc_ps2_a));
      end
      if (ok_b) begin
        m_valid[ib] = 1; m_picked[ib] = 0; m_fu[ib] = int'(alloc_fu_b);
        m_t1[ib] = int'(alloc_ps1_b); m_t2[ib] = int'(alloc_ps2_b);
        m_r1[ib] = alloc_rdy1_b || woken(int'(alloc_ps1_b));
        m_r2[ib] = alloc_rdy2_b || woken(int'(alloc_ps2_b));
      end
    end
  endtask

  task automatic compare_all();
    int fr;
    fr = m_free();
    for (int f = 0; f < 3; f++) begin
      check($sformatf("cyc issue_valid[%0d]", f), int'(issue_valid[f]), int'(m_iv[f]));
      if (m_iv[f]) check($sformatf("cyc issue_idx_%0d", f), dut_idx(f), m_idx[f]);
    end
    check("cyc free_count", int'(free_count), fr);
    check("cyc dispatch_stall", int'(dispatch_stall), (fr < 2) ? 1 : 0);
    check("cyc alloc_err", int'(alloc_err), int'(m_err));
  endtask

  task automatic clear_pulses();
    alloc_valid_a = 0; alloc_valid_b = 0; wake_valid = '0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    clear_pulses();
    @(negedge clk);
    if (rst_n) compare_all();
  endtask

  task automatic set_a(input int idx, input int fu, input int p1, input int p2,
                       input int r1, input int r2);
    alloc_valid_a = 1; alloc_idx_a = 4'(idx); alloc_fu_a = 2'(fu);
    alloc_ps1_a = 6'(p1); alloc_ps2_a = 6'(p2); alloc_rdy1_a = 1'(r1); alloc_rdy2_a = 1'(r2);
  endtask

  task automatic set_b(input int idx, input int fu, input int p1, input int p2,
                       input int r1, input int r2);
    alloc_valid_b = 1; alloc_idx_b = 4'(idx); alloc_fu_b = 2'(fu);
    alloc_ps1_b = 6'(p1); alloc_ps2_b = 6'(p2); alloc_rdy1_b = 1'(r1); alloc_rdy2_b = 1'(r2);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, " issue_valid"}, int'(issue_valid), 0);
    check({tag, " issue_idx_0"}, int'(issue_idx_0), 0);
    check({tag, " issue_idx_1"}, int'(issue_idx_1), 0);
    check({tag, " issue_idx_2"}, int'(issue_idx_2), 0);
    check({tag, " free_count"}, int'(free_count), 16);
    check({tag, " dispatch_stall"}, int'(dispatch_stall), 0);
    check({tag, " alloc_err"}, int'(alloc_err), 0);
  endtask

  initial begin
    rst_n = 1; clear_pulses(); issue_ready = '0;
    alloc_idx_a = '0; alloc_idx_b = '0; alloc_fu_a = '0; alloc_fu_b = '0;
    alloc_ps1_a = '0; alloc_ps2_a = '0; alloc_ps1_b = '0; alloc_ps2_b = '0;
    alloc_rdy1_a = 0; alloc_rdy2_a = 0; alloc_rdy1_b = 0; alloc_rdy2_b = 0;
    wake_tag_0 = '0; wake_tag_1 = '0; wake_tag_2 = '0;
    model_reset();
    #2 rst_n = 0;
    #10 reset_checks("reset");
    #1 rst_n = 1;

    // Simple ready allocation, issue and free.
    issue_ready = 3'b111;
    set_a(0, 0, 1, 2, 1, 1); tick();
    check("t1 free after alloc", int'(free_count), 15);
    tick();
    check("t1 issue_valid", int'(issue_valid), 1);
    check("t1 issue_idx_0", int'(issue_idx_0), 0);
    tick();
    check("t1 free after issue", int'(free_count), 16);
    check("t1 issue_valid idle", int'(issue_valid), 0);

    // Late wakeup, then wakeup in the allocation cycle.
    set_a(3, 2, 9, 10, 0, 1); tick(); tick();
    wake_valid = 3'b010; wake_tag_1 = 6'd9; tick();
    check("t2 not before wake+1", int'(issue_valid), 0);
    tick();
    check("t2 issue_valid", int'(issue_valid), 3'b100);
    check("t2 issue_idx_2", int'(issue_idx_2), 3);
    tick();
    check("t2 freed", int'(free_count), 16);
    set_a(3, 2, 9, 10, 0, 1); wake_valid = 3'b010; wake_tag_1 = 6'd9; tick(); tick();
    check("t2b issue_valid", int'(issue_valid), 3'b100);
    check("t2b issue_idx_2", int'(issue_idx_2), 3);
    tick();

    // Round-robin on port 0.
    set_a(1, 0, 1, 2, 1, 1); set_b(5, 0, 1, 2, 1, 1); tick();
    set_a(9, 0, 1, 2, 1, 1); tick();
    check("t3 rr first", int'(issue_idx_0), 1);
    tick(); check("t3 rr second", int'(issue_idx_0), 5);
    tick(); check("t3 rr third", int'(issue_idx_0), 9);
    tick(); check("t3 drained", int'(issue_valid), 0);
    set_a(1, 0, 1, 2, 1, 1); set_b(5, 0, 1, 2, 1, 1); tick(); tick();
    check("t3 wrap first", int'(issue_idx_0), 1);
    tick(); check("t3 wrap second", int'(issue_idx_0), 5);
    tick();

    // Backpressure hold on port 1 while port 0 keeps flowing.
    issue_ready = 3'b101;
    set_a(2, 1, 1, 2, 1, 1); set_b(6, 1, 1, 2, 1, 1); tick();
    set_a(8, 0, 1, 2, 1, 1); tick();
    for (int i = 0; i < 4; i++) begin
      check("t4 hold valid1", int'(issue_valid[1]), 1);
      check("t4 hold idx1", int'(issue_idx_1), 2);
      tick();
    end
    issue_ready = 3'b111; tick();
    check("t4 next idx1", int'(issue_idx_1), 6);
    tick();
    check("t4 drained", int'(issue_valid), 0);
    check("t4 free", int'(free_count), 16);

    // Fill 15 entries (not ready), then illegal allocations.
    for (int e = 0; e < 14; e += 2) begin
      set_a(e, e % 3, 63, 62, 0, 1); set_b(e + 1, (e + 1) % 3, 63, 62, 0, 1); tick();
    end
    set_a(14, 2, 63, 62, 0, 1); tick();
    check("t5 free 1", int'(free_count), 1);
    check("t5 stall", int'(dispatch_stall), 1);
    check("t5 no err yet", int'(alloc_err), 0);
    set_a(4, 0, 1, 2, 1, 1); tick();
    check("t5 err on valid idx", int'(alloc_err), 1);
    check("t5 free unchanged", int'(free_count), 1);
    tick();
    check("t5 entry 4 untouched", int'(issue_valid), 0);
    set_a(15, 1, 20, 21, 0, 1); set_b(15, 0, 1, 2, 1, 1); tick();
    check("t5 only A written", int'(free_count), 0);
    wake_valid = 3'b001; wake_tag_0 = 6'd20; tick(); tick();
    check("t5 A issues on port 1", int'(issue_valid), 3'b010);
    check("t5 A idx", int'(issue_idx_1), 15);
    tick();
    check("t5 free after A", int'(free_count), 1);

    // Three ports held, then flush (allocation in the flush cycle is dropped).
    issue_ready = 3'b000;
    wake_valid = 3'b100; wake_tag_2 = 6'd63; tick(); tick();
    check("t6 all valid", int'(issue_valid), 3'b111);
    check("t6 idx0", int'(issue_idx_0), 9);
    check("t6 idx1", int'(issue_idx_1), 1);
    check("t6 idx2", int'(issue_idx_2), 5);
    flush = 1; set_a(15, 0, 1, 2, 1, 1); tick();
    check("t6 flushed valid", int'(issue_valid), 0);
    check("t6 flushed free", int'(free_count), 16);
    check("t6 err sticky", int'(alloc_err), 1);

    // Asynchronous reset between edges.
    set_a(11, 0, 1, 2, 1, 1); tick(); tick();
    check("t7 pre-reset idx0", int'(issue_idx_0), 11);
    #2 rst_n = 0; model_reset();
    #1 reset_checks("async");
    rst_n = 1;

    // Reallocating an index in its own handshake cycle, then illegal fu code.
    issue_ready = 3'b111;
    set_a(2, 0, 1, 2, 1, 1); tick(); tick();
    check("t8 offered idx0", int'(issue_idx_0), 2);
    set_a(2, 1, 1, 2, 1, 1); tick();
    check("t8 same-cycle realloc err", int'(alloc_err), 1);
    check("t8 free", int'(free_count), 16);
    set_a(2, 1, 1, 2, 1, 1); tick();
    check("t8 realloc next cycle", int'(free_count), 15);
    tick(); tick();
    check("t8 drained", int'(free_count), 16);
    #2 rst_n = 0; model_reset();
    #1 rst_n = 1;
    set_a(7, 3, 1, 2, 1, 1); set_b(8, 2, 1, 2, 1, 1); tick();
    check("t8 fu3 err", int'(alloc_err), 1);
    check("t8 fu3 dropped", int'(free_count), 15);
    tick();
    check("t8 B issues", int'(issue_valid), 3'b100);
    check("t8 B idx", int'(issue_idx_2), 8);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
